imm_encoder: RTL

Packs instruction fields into 32-bit LEGv8 words: LDUR/STUR (D-format) and CBZ (CB-format). It is the inverse of the decode-side immediate sign-extender. Each request carries a 64-bit immediate, which is range-checked and then truncated into the instruction's immediate field. The block sits between the test/program loader and instruction memory, and buffers encoded words in a small FIFO with valid/ready handshakes on both sides.

---
 rtl/imm_encoder.sv | 95 +++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// LEGv8 D-format (LDUR/STUR) and CB-format (CBZ) instruction packer with range-checked
// immediates, buffering {err, instr} entries in a small valid/ready FIFO.
module imm_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rn,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {
        KindLdur = 2'b00,
        KindStur = 2'b01,
        KindCbz  = 2'b10,
        KindRsvd = 2'b11
    } kind_e;

    logic        d_fits;
    logic        cb_fits;
    logic        enc_err;
    logic [31:0] enc_instr;

    // Legal when every bit above the field's sign bit replicates it.
    always_comb begin
        d_fits    = (in_imm[63:8] == {56{in_imm[8]}});
        cb_fits   = (in_imm[1:0] == 2'b00) && (in_imm[63:20] == {44{in_imm[20]}});
        enc_err   = 1'b0;
        enc_instr = '0;
        case (kind_e'(in_kind))
            KindLdur: begin
                if (d_fits) enc_instr = {11'h7C2, in_imm[8:0], 2'b00, in_rn, in_rt};
                else        enc_err   = 1'b1;
            end
            KindStur: begin
                if (d_fits) enc_instr = {11'h7C0, in_imm[8:0], 2'b00, in_rn, in_rt};
                else        enc_err   = 1'b1;
            end
            KindCbz: begin
                if (cb_fits) enc_instr = {8'hB4, in_imm[20:2], in_rt};
                else         enc_err   = 1'b1;
            end
            default: enc_err = 1'b1;
        endcase
    end

    logic [32:0]     mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            push;
    logic            pop;

    always_comb begin
        in_ready  = (count != Full);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_instr = out_valid ? mem[rd_ptr][31:0] : 32'h0;
        out_err   = out_valid ? mem[rd_ptr][32] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enc_err, enc_instr};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (push && !pop)      count <= count + CntW'(1);
            else if (pop && !push) count <= count - CntW'(1);
            if (push && enc_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule
